wr_master: RTL
==============

WR_MASTER -- requirements
Module: wr_master

Interface
REQ-001 Parameter ADDR_W, default 32, sets the address width for AWADDR and cmd_addr.
REQ-002 Parameter DATA_W, default 32, sets the data width for WDATA and cmd_data.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  command request; sampled only in IDLE.
REQ-006 cmd_addr  in  ADDR_W  write address, captured when start is accepted.
REQ-007 cmd_data  in  DATA_W  write data, captured when start is accepted.
REQ-008 busy  out  1  high whenever the state is not IDLE.
REQ-009 done  out  1  one-cycle pulse when a transaction completes.
REQ-010 resp  out  2  BRESP of the last completed transaction; held until the next completion.
REQ-011 err  out  1  high with done when resp != 2'b00; held with resp.
REQ-012 AWADDR  out  ADDR_W  write address to slave.
REQ-013 AWVALID  out  1  address valid.
REQ-014 AWREADY  in  1  slave address ready.
REQ-015 WDATA  out  DATA_W  write data to slave.
REQ-016 WVALID  out  1  data valid.
REQ-017 WREADY  in  1  slave data ready.
REQ-018 BVALID  in  1  slave response valid.
REQ-019 BRESP  in  2  slave response code.
REQ-020 BREADY  out  1  master response ready.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, SEND and WAIT_B.
REQ-022 In IDLE with start=1 at an edge, the block SHALL capture cmd_addr/cmd_data into AWADDR/WDATA and go to SEND, with AWVALID=WVALID=1 from the next cycle.
REQ-023 start while busy=1 SHALL be ignored, with no queuing.
REQ-024 AW and W handshakes are independent; each completes on an edge where its VALID and READY are both 1.
REQ-025 Each VALID SHALL drop in the cycle after its own handshake and SHALL NOT drop before it.
REQ-026 AWADDR and WDATA SHALL stay stable while their VALID is high.
REQ-027 The block SHALL track completion with two flags, aw_done and w_done; handshakes may occur in either order or on the same edge.
REQ-028 When both handshakes are complete (including both on one edge), the FSM SHALL go to WAIT_B and set BREADY=1 from the next cycle.
REQ-029 BREADY SHALL be 0 in every state except WAIT_B.
REQ-030 In WAIT_B, on the edge with BVALID=1, the block SHALL capture BRESP into resp, set err=(BRESP!=0), drop BREADY, pulse done for one cycle and go to IDLE.
REQ-031 A BVALID seen outside WAIT_B SHALL be ignored.
REQ-032 A start in the done cycle SHALL be accepted, giving back-to-back transactions.
REQ-033 With the slave always ready, the minimum latency SHALL be 3 cycles from the start edge to the done-high cycle.
REQ-034 The block SHALL have no timeout: it waits indefinitely for READY or BVALID.

Reset
REQ-035 While rst=1, the block SHALL immediately (asynchronously) force state=IDLE, AWVALID=WVALID=BREADY=0, busy=done=err=0, resp=2'b00, AWADDR=WDATA=0 and clear aw_done/w_done.
REQ-036 Reset mid-transaction SHALL abandon the transaction with no done pulse; the first edge after rst falls is treated as IDLE.

Verification
REQ-037 Slave always ready, start with addr 0x0000_1234 and data 0xABCD_EF01, BVALID one cycle after W -> done at cycle 3, resp=00, err=0, AWADDR/WDATA match.
REQ-038 AWREADY delayed 4 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles with AWADDR stable, BREADY rises only after AW.
REQ-039 WREADY delayed 3 cycles, AWREADY immediate -> mirror of REQ-038 behaviour; a single done pulse.
REQ-040 BRESP=2'b10 (SLVERR) -> done with resp=10 and err=1, held until the next completion; next OKAY transaction clears err.
REQ-041 start pulsed 5 times while busy, then start in the done cycle -> exactly 2 transactions, second beginning with no idle gap.
REQ-042 rst asserted while AWVALID=1 and awaiting AWREADY -> outputs zero without waiting for an edge, no done pulse, a new start after reset completes normally.

Source files
------------

// File: rtl/wr_master.sv
// wr_master: single-beat AXI write master; one command in, one AW/W/B transaction out.
module wr_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              busy,
   output logic              done,
   output logic [1:0]        resp,
   output logic              err,
   output logic [ADDR_W-1:0] AWADDR,
   output logic              AWVALID,
   input  logic              AWREADY,
   output logic [DATA_W-1:0] WDATA,
   output logic              WVALID,
   input  logic              WREADY,
   input  logic              BVALID,
   input  logic [1:0]        BRESP,
   output logic              BREADY
);
   typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;
   state_t              state_q;
   logic [ADDR_W-1:0]   awaddr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                awvalid_q, wvalid_q, bready_q, done_q, err_q;
   logic                aw_done_q, w_done_q;
   logic [1:0]          resp_q;
   logic                aw_hs, w_hs, aw_all, w_all;
   assign aw_hs  = awvalid_q && AWREADY;
   assign w_hs   = wvalid_q && WREADY;
   // a handshake on this edge counts as complete, so both landing together advance at once
   assign aw_all = aw_done_q || aw_hs;
   assign w_all  = w_done_q || w_hs;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         resp_q    <= 2'b00;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               awaddr_q  <= cmd_addr;
               wdata_q   <= cmd_data;
               awvalid_q <= 1'b1;
               wvalid_q  <= 1'b1;
               aw_done_q <= 1'b0;
               w_done_q  <= 1'b0;
               state_q   <= SEND;
            end
            SEND: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
               if (aw_all && w_all) begin
                  bready_q <= 1'b1;
                  state_q  <= WAIT_B;
               end
            end
            WAIT_B: if (BVALID) begin
               resp_q   <= BRESP;
               err_q    <= |BRESP;
               bready_q <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign busy    = state_q != IDLE;
   assign done    = done_q;
   assign resp    = resp_q;
   assign err     = err_q;
   assign AWADDR  = awaddr_q;
   assign AWVALID = awvalid_q;
   assign WDATA   = wdata_q;
   assign WVALID  = wvalid_q;
   assign BREADY  = bready_q;
endmodule
